byte_serializer: RTL and testbench

BYTE_SERIALIZER -- requirements
Module: byte_serializer

---
 rtl/byte_serializer.sv | 183 ++++++++++++++++++
 tb/tb_byte_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serializer.sv
// -----------------------------------------------------------------------------
// byte_serializer
//
// Purpose: converts a WIDTH-bit parallel word into an MSB-first serial bit
// stream. One bit is delivered per edge on which bit_en is high. The serial
// output feeds a downstream sequence detector.
//
// Build option:
//   SER_PREFETCH_EN - when defined, adds a one-word holding buffer so that
//                     back-to-back words stream without an idle gap. When
//                     undefined, words are accepted only in IDLE, so at least
//                     one idle cycle separates consecutive words.
//
// Parameters:
//   WIDTH      parallel word width in bits (2..32)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   bit_en     in   bit-rate tick; a bit is delivered only when high
//   in_data    in   parallel word to serialize
//   in_valid   in   in_data valid
//   in_ready   out  block can accept a word this cycle
//   ser_bit    out  current serial bit (MSB of the shifter)
//   ser_valid  out  ser_bit holds a live bit
//   ser_last   out  ser_bit is the final bit of the current word
//   busy       out  shifter or holding buffer occupied
// -----------------------------------------------------------------------------
module byte_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [WIDTH-1:0] WORD_ZERO = WIDTH'(0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             take_s;

`ifdef SER_PREFETCH_EN
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;

    // With prefetch the block can take a word whenever the buffer is free.
    assign in_ready = !rst && !buf_full_q;
    assign busy     = !rst && ((state_q == SHIFT) || buf_full_q);
`else
    assign in_ready = !rst && (state_q == IDLE);
    assign busy     = !rst && (state_q == SHIFT);
`endif

    // Outputs come straight from flops; rst gating forces them low while
    // reset is held, even before the reset edge arrives.
    assign ser_valid = !rst && (state_q == SHIFT);
    assign ser_bit   = ser_valid && shift_q[WIDTH-1];
    assign ser_last  = ser_valid && (cnt_q == CNT_ZERO);

    assign take_s = in_valid && in_ready;

    // Next-state, shifter, counter and buffer update logic.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef SER_PREFETCH_EN
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
`endif
        case (state_q)
            IDLE: begin
                // bit_en has no effect here; only a transfer moves us on.
                if (take_s) begin
                    state_d = SHIFT;
                    shift_d = in_data;
                    cnt_d   = CNT_MAX;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (cnt_q == CNT_ZERO) begin
`ifdef SER_PREFETCH_EN
                        // Last bit leaves: refill from the buffer, or from a
                        // word arriving this very edge, to stay gapless.
                        if (buf_full_q) begin
                            shift_d    = buf_q;
                            cnt_d      = CNT_MAX;
                            buf_d      = WORD_ZERO;
                            buf_full_d = 1'b0;
                        end else if (take_s) begin
                            shift_d = in_data;
                            cnt_d   = CNT_MAX;
                        end else begin
                            state_d = IDLE;
                            shift_d = WORD_ZERO;
                            cnt_d   = CNT_ZERO;
                        end
`else
                        state_d = IDLE;
                        shift_d = WORD_ZERO;
                        cnt_d   = CNT_ZERO;
`endif
                    end else begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q - CNT_ONE;
`ifdef SER_PREFETCH_EN
                        if (take_s) begin
                            buf_d      = in_data;
                            buf_full_d = 1'b1;
                        end else begin
                            buf_full_d = buf_full_q;
                        end
`endif
                    end
                end else begin
`ifdef SER_PREFETCH_EN
                    if (take_s) begin
                        buf_d      = in_data;
                        buf_full_d = 1'b1;
                    end else begin
                        buf_full_d = buf_full_q;
                    end
`else
                    state_d = SHIFT;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                shift_d = WORD_ZERO;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State register; synchronous reset wins over any transfer or delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= WORD_ZERO;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SER_PREFETCH_EN
    // Holding buffer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q      <= WORD_ZERO;
            buf_full_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end
`endif

endmodule

// File: tb/tb_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_byte_serializer
//
// Directed bench for byte_serializer (WIDTH=8). Expected serial bits are
// pushed to a scoreboard queue when a word is driven and popped by a monitor
// on every delivered bit. Works in both the default and SER_PREFETCH_EN
// builds.
// -----------------------------------------------------------------------------
module tb_byte_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_en;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         ser_bit;
    logic         ser_valid;
    logic         ser_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic b;
        logic l;
    } exp_t;

    exp_t sb[$];

    // Reference model of the downstream 11011 overlapping detector.
    logic       det_en = 1'b0;
    logic [4:0] det_hist = 5'd0;
    int         det_seen = 0;
    int         det_matches = 0;

    byte_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d);
        exp_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.b = d[i];
            e.l = (i == 0);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a bit is consumed on the next edge when ser_valid and bit_en.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ser_valid && bit_en) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow observed=%0d expected=nonzero", sb.size());
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ser_bit", ser_bit, e.b);
                chk("ser_last", ser_last, e.l);
            end
            if (det_en) begin
                det_hist = {det_hist[3:0], ser_bit};
                det_seen++;
                if (det_seen >= 5 && det_hist == 5'b11011) det_matches++;
            end
        end
    end

    // Count ser_valid cycles over a fixed window with bit_en driven by pattern.
    task automatic count_valid(input int cycles, input bit toggle, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            bit_en = toggle ? i[0] : 1'b1;
            if (ser_valid) n++;
            tick();
        end
        bit_en = 1'b1;
    endtask

    // Offer two words with in_valid held high; trace ser_valid/in_ready.
    task automatic send_two(input logic [W-1:0] w0, input logic [W-1:0] w1,
                            output int ones, output int gap,
                            output int rdy_while_valid, output int rdy_low_cycles);
        int sent;
        int first;
        int last;
        sent = 0; ones = 0; first = -1; last = -1;
        rdy_while_valid = 0; rdy_low_cycles = 0;
        push_word(w0);
        push_word(w1);
        in_valid = 1'b1;
        in_data  = w0;
        for (int i = 0; i < 40; i++) begin
            logic acc;
            acc = in_valid && in_ready;
            if (ser_valid) begin
                ones++;
                if (first < 0) first = i;
                last = i;
                if (in_ready) rdy_while_valid++;
                else rdy_low_cycles++;
            end
            tick();
            if (acc) begin
                sent++;
                if (sent == 1) in_data = w1;
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("send_two_accepted", sent, 2);
        gap = (first < 0) ? -1 : (last - first + 1 - ones);
    endtask

    initial begin
        int n;
        int ones;
        int gap;
        int rvv;
        int rlow;

        rst      = 1'b1;
        bit_en   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_ser_valid", ser_valid, 1'b0);
        chk("rst_ser_bit", ser_bit, 1'b0);
        chk("rst_ser_last", ser_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // bit_en in IDLE does nothing.
        bit_en = 1'b1;
        tick();
        tick();
        chk("idle_bit_en_valid", ser_valid, 1'b0);
        chk("idle_bit_en_busy", busy, 1'b0);

        // Single word 8'hDB at full bit rate.
        in_valid = 1'b1;
        in_data  = 8'hDB;
        push_word(8'hDB);
        tick();
        in_valid = 1'b0;
        in_data  = 8'hFF;
        chk("db_first_valid", ser_valid, 1'b1);
        chk("db_first_bit", ser_bit, 1'b1);
        chk("db_busy", busy, 1'b1);
        count_valid(20, 1'b0, n);
        chk("db_valid_cycles", n, 8);
        chk("db_sb_empty", sb.size(), 0);
        chk("db_idle_bit", ser_bit, 1'b0);
        chk("db_idle_busy", busy, 1'b0);

        // Word 8'hA5 with bit_en alternating: each bit held two cycles.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        push_word(8'hA5);
        tick();
        in_valid = 1'b0;
        count_valid(40, 1'b1, n);
        chk("a5_valid_cycles", n, 16);
        chk("a5_sb_empty", sb.size(), 0);

        // Back-to-back words with in_valid held high.
        send_two(8'h1B, 8'h6C, ones, gap, rvv, rlow);
        chk("b2b_valid_cycles", ones, 16);
        chk("b2b_sb_empty", sb.size(), 0);
`ifdef SER_PREFETCH_EN
        chk("b2b_gap", gap, 0);
        chk("b2b_ready_dropped", (rlow > 0), 1'b1);
`else
        chk("b2b_gap", gap, 1);
        chk("b2b_ready_in_shift", rvv, 0);
`endif

        // Reset after 3 bits of 8'hFF, then a clean 8'h80.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        push_word(8'hFF);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_sb_left", sb.size(), 5);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("abort_rst_valid", ser_valid, 1'b0);
        tick();
        chk("abort_valid", ser_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h80;
        push_word(8'h80);
        tick();
        in_valid = 1'b0;
        count_valid(20, 1'b0, n);
        chk("w80_valid_cycles", n, 8);
        chk("w80_sb_empty", sb.size(), 0);

        // End-to-end stream into the detector model.
        det_en = 1'b1;
        send_two(8'hDB, 8'h6C, ones, gap, rvv, rlow);
        det_en = 1'b0;
        chk("det_bits_seen", det_seen, 16);
        chk("det_matches", det_matches, 4);
        chk("det_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
